wb_pipe_reg: RTL and testbench
==============================

Name: wb_pipe_reg

Overview:
- Parametrised successor of the single-stage MEM/WB pipeline register.
- Carries writeback control and data through DEPTH register stages, from the memory-stage outputs to the register-file write port.
- Adds per-stage valid, stall (hold), flush (kill), bubble insertion and a registered writeback-data select.
- Optionally provides a forwarding lookup across all in-flight stages for the hazard unit.

Parameters:
- DATA_W, 32, width of ALURes and memReadVal.
- DEST_W, 5, width of the destination register index.
- DEPTH, 1, number of register stages, legal range 1..4; DEPTH=1 matches classic MEM/WB timing.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold every stage unchanged.
- flush  in  1  kill every in-flight entry.
- validIn  in  1  incoming entry is real; 0 inserts a bubble.
- WB_EN_IN  in  1  write-back enable of incoming entry.
- MEM_R_EN_IN  in  1  incoming entry is a load.
- destIn  in  DEST_W  destination register of incoming entry.
- ALUResIn  in  DATA_W  ALU result.
- memReadValIn  in  DATA_W  load data.
- valid  out  1  last stage holds a real entry.
- WB_EN  out  1  last-stage write enable, already qualified by valid.
- MEM_R_EN  out  1  last-stage load flag.
- dest  out  DEST_W  last-stage destination.
- ALURes  out  DATA_W  last-stage ALU result.
- memReadVal  out  DATA_W  last-stage load data.
- wbData  out  DATA_W  registered writeback value.
- fwdSrc1, fwdSrc2  in  DEST_W  source registers to look up (PIPE_REG_FWD_EN only).
- fwdHit1, fwdHit2  out  1  lookup hit (PIPE_REG_FWD_EN only).
- fwdVal1, fwdVal2  out  DATA_W  forwarded value (PIPE_REG_FWD_EN only).

Behaviour:
- Reset: one rising clk edge with rst=1 clears every stage: valid, WB_EN, MEM_R_EN, dest, ALURes, memReadVal and wbData all become 0.
  - rst has priority over flush and stall.
  - Reset asserted mid-stream discards all entries.
- Stages are numbered 0 (input side) to DEPTH-1 (output side). All outputs come from stage DEPTH-1. Latency from input to output is DEPTH cycles.
- Each edge, priority order: rst > flush > stall > advance.
- flush=1:
  - Every stage valid, WB_EN and MEM_R_EN become 0.
  - Data fields are don't-care; they hold.
  - Whatever is presented on the inputs that cycle is discarded.
- stall=1 (flush=0): every stage holds all fields. Inputs are ignored, with no skid buffer; upstream must hold its value.
- Advance (stall=0, flush=0):
  - Stage k loads from stage k-1; stage 0 loads from the inputs.
  - Stage 0 valid = validIn.
  - Stage 0 WB_EN = WB_EN_IN & validIn.
  - Stage 0 MEM_R_EN = MEM_R_EN_IN & validIn.
  - dest, ALURes and memReadVal load unconditionally, including on bubbles.
- wbData is computed at stage 0 load as MEM_R_EN_IN ? memReadValIn : ALUResIn. It travels with its entry.
- Invariant at every stage: WB_EN=1 implies valid=1.
- No arithmetic; all widths pass through unchanged.

Optional Feature:
- Macro: PIPE_REG_FWD_EN.
- Defined:
  - fwdSrc*/fwdHit*/fwdVal* ports exist.
  - fwdHitN is combinational: 1 if any stage has WB_EN=1, dest==fwdSrcN and dest!=0.
  - On multiple hits, the youngest stage (lowest index) wins.
  - fwdValN is that stage's wbData, else 0.
  - Lookup sees the current register state, i.e. before the edge.
  - A flushed or bubble stage never hits.
  - Register 0 never hits.
- Undefined: the forwarding ports and logic are absent. The hazard unit must then stall on any in-flight dependency.

Test Plan:
- Reset and pipeline (DEPTH=1):
  - Hold rst 2 cycles → all outputs 0.
  - Then validIn=1, WB_EN_IN=1, MEM_R_EN_IN=1, destIn=7, memReadValIn=0xDEADBEEF, ALUResIn=0x10.
  - Next edge → valid=1, WB_EN=1, dest=7, wbData=0xDEADBEEF.
- Bubble: validIn=0 with WB_EN_IN=1 → after the edge WB_EN=0, MEM_R_EN=0, valid=0.
- Stall/flush (DEPTH=3):
  - Feed dest 1,2,3 on consecutive cycles.
  - Assert stall 2 cycles → dest output frozen at 1, no entry lost.
  - Release → 2 then 3 appear.
  - Assert flush and stall together → next edge all valid=0, the input entry is discarded.
- Reset mid-stream: DEPTH=4 full of valid entries, rst for 1 cycle → all stages zero on that edge; the entry presented that cycle never appears.
- Forwarding (PIPE_REG_FWD_EN, DEPTH=2):
  - Stage 0 dest=5 wbData=0xAA and stage 1 dest=5 wbData=0xBB, fwdSrc1=5 → fwdHit1=1, fwdVal1=0xAA.
  - fwdSrc2=0 while a stage holds dest=0 with WB_EN=1 → fwdHit2=0.
- Forward kill: stage 0 holds dest=9 with WB_EN=1, then flush → next cycle fwdSrc1=9 gives fwdHit1=0.

Source files
------------

// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: DEPTH-stage MEM/WB pipeline register with valid, stall, flush, bubble
// insertion and registered writeback select. Define PIPE_REG_FWD_EN to add the forwarding lookup.
module wb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              validIn,
    input  logic              WB_EN_IN,
    input  logic              MEM_R_EN_IN,
    input  logic [DEST_W-1:0] destIn,
    input  logic [DATA_W-1:0] ALUResIn,
    input  logic [DATA_W-1:0] memReadValIn,
    output logic              valid,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic [DEST_W-1:0] dest,
    output logic [DATA_W-1:0] ALURes,
    output logic [DATA_W-1:0] memReadVal,
    output logic [DATA_W-1:0] wbData
`ifdef PIPE_REG_FWD_EN
    ,
    input  logic [DEST_W-1:0] fwdSrc1,
    input  logic [DEST_W-1:0] fwdSrc2,
    output logic              fwdHit1,
    output logic              fwdHit2,
    output logic [DATA_W-1:0] fwdVal1,
    output logic [DATA_W-1:0] fwdVal2
`endif
);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_wb_en;
    logic [DEPTH-1:0]  r_mem_r_en;
    logic [DEST_W-1:0] r_dest [DEPTH];
    logic [DATA_W-1:0] r_alu  [DEPTH];
    logic [DATA_W-1:0] r_mem  [DEPTH];
    logic [DATA_W-1:0] r_wb   [DEPTH];

    logic [DATA_W-1:0] w_wb_sel;

    // Writeback mux is resolved on entry so it travels with its entry.
    assign w_wb_sel = MEM_R_EN_IN ? memReadValIn : ALUResIn;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_wb_en    <= '0;
            r_mem_r_en <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_dest[k] <= '0;
                r_alu[k]  <= '0;
                r_mem[k]  <= '0;
                r_wb[k]   <= '0;
            end
        end else if (flush) begin
            r_valid    <= '0;
            r_wb_en    <= '0;
            r_mem_r_en <= '0;
        end else if (!stall) begin
            r_valid[0]    <= validIn;
            r_wb_en[0]    <= WB_EN_IN & validIn;
            r_mem_r_en[0] <= MEM_R_EN_IN & validIn;
            r_dest[0]     <= destIn;
            r_alu[0]      <= ALUResIn;
            r_mem[0]      <= memReadValIn;
            r_wb[0]       <= w_wb_sel;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k]    <= r_valid[k-1];
                r_wb_en[k]    <= r_wb_en[k-1];
                r_mem_r_en[k] <= r_mem_r_en[k-1];
                r_dest[k]     <= r_dest[k-1];
                r_alu[k]      <= r_alu[k-1];
                r_mem[k]      <= r_mem[k-1];
                r_wb[k]       <= r_wb[k-1];
            end
        end
    end

    assign valid      = r_valid[DEPTH-1];
    assign WB_EN      = r_wb_en[DEPTH-1] & r_valid[DEPTH-1];
    assign MEM_R_EN   = r_mem_r_en[DEPTH-1];
    assign dest       = r_dest[DEPTH-1];
    assign ALURes     = r_alu[DEPTH-1];
    assign memReadVal = r_mem[DEPTH-1];
    assign wbData     = r_wb[DEPTH-1];

`ifdef PIPE_REG_FWD_EN
    // Scan oldest to youngest so the lowest-index (youngest) hit overrides.
    always_comb begin
        fwdHit1 = 1'b0;
        fwdVal1 = '0;
        fwdHit2 = 1'b0;
        fwdVal2 = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (r_wb_en[k] && (r_dest[k] == fwdSrc1) && (fwdSrc1 != '0)) begin
                fwdHit1 = 1'b1;
                fwdVal1 = r_wb[k];
            end
            if (r_wb_en[k] && (r_dest[k] == fwdSrc2) && (fwdSrc2 != '0)) begin
                fwdHit2 = 1'b1;
                fwdVal2 = r_wb[k];
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Scoreboard bench for wb_pipe_reg: four instances (DEPTH 1..4) share one stimulus stream
// and are compared each cycle against a queue-based model of in-flight entries.
module tb_wb_pipe_reg;

    localparam int NDUT = 4;
    localparam int K_A = 0, K_S = 1, K_F = 2, K_R = 3;

    typedef struct packed {
        logic        v;
        logic        we;
        logic        mr;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] wb;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, stall, validIn, WB_EN_IN, MEM_R_EN_IN;
    logic [4:0]  destIn;
    logic [31:0] ALUResIn, memReadValIn;
    logic [4:0]  fwdSrc1, fwdSrc2;

    logic        valid_o [NDUT];
    logic        wben_o  [NDUT];
    logic        memr_o  [NDUT];
    logic [4:0]  dest_o  [NDUT];
    logic [31:0] alu_o   [NDUT];
    logic [31:0] mem_o   [NDUT];
    logic [31:0] wb_o    [NDUT];
`ifdef PIPE_REG_FWD_EN
    logic        hit1_o [NDUT];
    logic        hit2_o [NDUT];
    logic [31:0] val1_o [NDUT];
    logic [31:0] val2_o [NDUT];
`endif

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        wb_pipe_reg #(.DATA_W(32), .DEST_W(5), .DEPTH(g + 1)) u_dut (
            .clk(clk), .rst(rst), .stall(stall), .flush(flush),
            .validIn(validIn), .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN),
            .destIn(destIn), .ALUResIn(ALUResIn), .memReadValIn(memReadValIn),
            .valid(valid_o[g]), .WB_EN(wben_o[g]), .MEM_R_EN(memr_o[g]),
            .dest(dest_o[g]), .ALURes(alu_o[g]), .memReadVal(mem_o[g]),
            .wbData(wb_o[g])
`ifdef PIPE_REG_FWD_EN
            ,
            .fwdSrc1(fwdSrc1), .fwdSrc2(fwdSrc2),
            .fwdHit1(hit1_o[g]), .fwdHit2(hit2_o[g]),
            .fwdVal1(val1_o[g]), .fwdVal2(val2_o[g])
`endif
        );
    end

    // q[i] holds entries still inside DUT i below its output stage (back = youngest);
    // cur[i] is what DUT i's output stage must show.
    ent_t q [NDUT][$];
    ent_t cur [NDUT];
    int   kind_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 1'b0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s depth=%0d t=%0t: got %0h expected %0h", nm, i + 1, $time, act, exp);
        end
    endtask

    task automatic apply(input int i, input int k);
        ent_t e;
        case (k)
            K_R: begin
                q[i].delete();
                for (int j = 0; j < i; j++) q[i].push_back('0);
                cur[i] = '0;
            end
            K_F: begin
                cur[i].v  = 1'b0;
                cur[i].we = 1'b0;
                cur[i].mr = 1'b0;
                for (int j = 0; j < q[i].size(); j++) begin
                    e = q[i][j];
                    e.v = 1'b0; e.we = 1'b0; e.mr = 1'b0;
                    q[i][j] = e;
                end
            end
            K_A: begin
                if (q[i].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty depth=%0d t=%0t: got 0 entries expected >0", i + 1, $time);
                end else begin
                    cur[i] = q[i].pop_front();
                end
            end
            default: ;
        endcase
    endtask

    task automatic fwd_exp(input int i, input logic [4:0] src, output logic hit, output logic [31:0] val);
        hit = 1'b0;
        val = '0;
        if (src != 5'd0) begin
            for (int j = q[i].size() - 1; j >= 0; j--) begin
                if (!hit && q[i][j].we && q[i][j].dest == src) begin
                    hit = 1'b1;
                    val = q[i][j].wb;
                end
            end
            if (!hit && cur[i].we && cur[i].dest == src) begin
                hit = 1'b1;
                val = cur[i].wb;
            end
        end
    endtask

    task automatic compare(input int i);
        logic        h;
        logic [31:0] v;
        chk("valid",      i, 32'(valid_o[i]), 32'(cur[i].v));
        chk("WB_EN",      i, 32'(wben_o[i]),  32'(cur[i].we));
        chk("MEM_R_EN",   i, 32'(memr_o[i]),  32'(cur[i].mr));
        chk("dest",       i, 32'(dest_o[i]),  32'(cur[i].dest));
        chk("ALURes",     i, alu_o[i],        cur[i].alu);
        chk("memReadVal", i, mem_o[i],        cur[i].mem);
        chk("wbData",     i, wb_o[i],         cur[i].wb);
`ifdef PIPE_REG_FWD_EN
        fwd_exp(i, fwdSrc1, h, v);
        chk("fwdHit1", i, 32'(hit1_o[i]), 32'(h));
        chk("fwdVal1", i, val1_o[i], v);
        fwd_exp(i, fwdSrc2, h, v);
        chk("fwdHit2", i, 32'(hit2_o[i]), 32'(h));
        chk("fwdVal2", i, val2_o[i], v);
`else
        h = 1'b0;
        v = '0;
`endif
    endtask

    // Monitor: consume the edge record produced by the driver, then check every instance.
    initial begin
        int k;
        forever begin
            @(negedge clk);
            #1;
            if (kind_q.size() > 0) begin
                k = kind_q.pop_front();
                for (int i = 0; i < NDUT; i++) apply(i, k);
                started = 1'b1;
            end
            if (started) begin
                for (int i = 0; i < NDUT; i++) compare(i);
            end
        end
    end

    task automatic cyc(input logic r, input logic f, input logic s, input logic v,
                       input logic we, input logic mr, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] s1, input logic [4:0] s2);
        ent_t e;
        @(negedge clk);
        rst = r; flush = f; stall = s; validIn = v; WB_EN_IN = we; MEM_R_EN_IN = mr;
        destIn = d; ALUResIn = alu; memReadValIn = mem; fwdSrc1 = s1; fwdSrc2 = s2;
        @(posedge clk);
        if (r)      kind_q.push_back(K_R);
        else if (f) kind_q.push_back(K_F);
        else if (s) kind_q.push_back(K_S);
        else begin
            e = '{v: v, we: we & v, mr: mr & v, dest: d, alu: alu, mem: mem, wb: (mr ? mem : alu)};
            for (int i = 0; i < NDUT; i++) q[i].push_back(e);
            kind_q.push_back(K_A);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; validIn = 1'b0; WB_EN_IN = 1'b0;
        MEM_R_EN_IN = 1'b0; destIn = '0; ALUResIn = '0; memReadValIn = '0;
        fwdSrc1 = '0; fwdSrc2 = '0;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 7, 32'h10, 32'hDEADBEEF, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 3, 32'h55, 32'h66, 7, 0);
        for (int j = 0; j < 4; j++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Three back-to-back entries, a two-cycle stall, then drain.
        cyc(0, 0, 0, 1, 1, 0, 1, 32'h101, 32'h201, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 2, 32'h102, 32'h202, 1, 2);
        cyc(0, 0, 0, 1, 1, 1, 3, 32'h103, 32'h203, 3, 2);
        cyc(0, 0, 1, 1, 1, 0, 4, 32'h104, 32'h204, 1, 3);
        cyc(0, 0, 1, 1, 1, 0, 4, 32'h104, 32'h204, 2, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        cyc(0, 0, 0, 1, 1, 0, 5, 32'h105, 32'h205, 0, 0);
        cyc(0, 1, 1, 1, 1, 0, 6, 32'h106, 32'h206, 5, 3);
        for (int j = 0; j < 4; j++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 5);

        // Full pipe, then reset while a new entry is presented.
        for (int j = 0; j < 4; j++) cyc(0, 0, 0, 1, 1, j[0], 5'(10 + j), 32'(j + 1), 32'(j + 100), 0, 0);
        cyc(1, 0, 0, 1, 1, 0, 15, 32'hBAD, 32'hBAD, 11, 12);
        for (int j = 0; j < 5; j++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 10);

        // Forwarding: two entries to r5 (youngest wins), r0 never hits, flush kills r9.
        cyc(0, 0, 0, 1, 1, 0, 5, 32'hBB, 32'h0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 5, 32'hAA, 32'h0, 5, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 32'h77, 32'h0, 5, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 0);
        cyc(0, 0, 0, 1, 1, 0, 9, 32'h99, 32'h0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 9, 9);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9);

        for (int j = 0; j < 600; j++) begin
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 70, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
